alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 39 +++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter.
//   state_t    - arbiter FSM state encoding
//   OP_*       - 3-bit ALU opcode constants
//   alu_req_t  - operation captured on the grant edge
//   pop4()     - population count of a 4-bit operand
package alu_arb_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_ZERO  = 3'b000;
    localparam logic [OP_W-1:0] OP_HOLD  = 3'b001;
    localparam logic [OP_W-1:0] OP_CAT   = 3'b010;
    localparam logic [OP_W-1:0] OP_PAIR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ANY   = 3'b100;
    localparam logic [OP_W-1:0] OP_LOGIC = 3'b101;
    localparam logic [OP_W-1:0] OP_ADD8  = 3'b110;
    localparam logic [OP_W-1:0] OP_RADD  = 3'b111;

    typedef struct packed {
        logic              id;
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } alu_req_t;

    function automatic logic [2:0] pop4(input logic [OPND_W-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU shared by both requesters.
//   op     in  3  opcode (OP_* from alu_arb_pkg)
//   a, b   in  4  operands
//   hold   in  8  hold register of the requester being served
//   result out 8  ALU result
module alu_core
    import alu_arb_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [RES_W-1:0]  hold,
    output logic [RES_W-1:0]  result
);

    logic [OPND_W:0]   carry;
    logic [OPND_W-1:0] sum;

    // Explicit ripple-carry chain of full adders
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < int'(OPND_W); i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    // Opcode decode
    always_comb begin
        result = '0;
        case (op)
            OP_RADD:  result = {3'b000, carry[OPND_W], sum};
            OP_ADD8:  result = RES_W'(a) + RES_W'(b);
            OP_LOGIC: result = {~(a & b), ~(a ^ b)};
            OP_ANY:   result = (|(a | b)) ? 8'h0F : 8'h00;
            OP_PAIR:  result = (pop4(a) == 3'd1 && pop4(b) == 3'd2) ? 8'hF0 : 8'h00;
            OP_CAT:   result = {a, ~b};
            OP_HOLD:  result = hold;
            OP_ZERO:  result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared ALU.
// Optional feature: define ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise requester 0 has fixed priority.
//   CLK            in   1  clock
//   reset          in   1  asynchronous active-high reset
//   req0, req1     in   1  level requests
//   op0, op1       in   3  opcodes
//   a0,b0,a1,b1    in   4  operands
//   ack0, ack1     out  1  one-cycle result-valid pulses
//   result         out  8  result, nonzero only alongside an ack
//   busy           out  1  high whenever the FSM is not IDLE
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
)
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [OPND_W-1:0] a0,
    input  logic [OPND_W-1:0] b0,
    input  logic [OPND_W-1:0] a1,
    input  logic [OPND_W-1:0] b1,
    output logic              ack0,
    output logic              ack1,
    output logic [RES_W-1:0]  result,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    alu_req_t           cur;
    logic               grant_id;
    logic               grant;
    logic [RES_W-1:0]   hold0;
    logic [RES_W-1:0]   hold1;
    logic [RES_W-1:0]   core_result;
    logic               ack0_nxt;
    logic               ack1_nxt;
    logic [RES_W-1:0]   result_nxt;
    logic               busy_nxt;

    assign grant = (state == ST_IDLE) && (req0 || req1);

`ifdef ROUND_ROBIN_EN
    logic last_id;

    // On contention favour whoever was not granted last
    always_comb begin
        grant_id = req1;
        if (req0 && req1) grant_id = ~last_id;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)      last_id <= 1'b1;
        else if (grant) last_id <= grant_id;
    end
`else
    // Requester 0 wins any contention
    always_comb begin
        grant_id = ~req0;
    end
`endif

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req0 || req1) state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == CNT_W'(EXEC_CYCLES - 1)) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        result_nxt = '0;
        busy_nxt   = (state_nxt != ST_IDLE);
        if (state == ST_RESP) begin
            ack0_nxt   = ~cur.id;
            ack1_nxt   = cur.id;
            result_nxt = core_result;
        end
    end

    // EXEC dwell counter
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)                 cnt <= '0;
        else if (state == ST_EXEC) cnt <= cnt + CNT_W'(1);
        else                       cnt <= '0;
    end

    // Capture the granted operation so later input changes are ignored
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cur <= '0;
        end else if (grant) begin
            cur.id <= grant_id;
            cur.op <= grant_id ? op1 : op0;
            cur.a  <= grant_id ? a1  : a0;
            cur.b  <= grant_id ? b1  : b0;
        end
    end

    alu_core u_core (
        .op     (cur.op),
        .a      (cur.a),
        .b      (cur.b),
        .hold   (cur.id ? hold1 : hold0),
        .result (core_result)
    );

    // Registered outputs and per-requester hold registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            hold0  <= '0;
            hold1  <= '0;
        end else begin
            ack0   <= ack0_nxt;
            ack1   <= ack1_nxt;
            result <= result_nxt;
            busy   <= busy_nxt;
            if (state == ST_RESP && !cur.id) hold0 <= core_result;
            if (state == ST_RESP &&  cur.id) hold1 <= core_result;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. Requester tasks drive
// stimulus and queue expected acks; a negedge monitor pops and compares.
module tb_alu_arbiter;

    localparam int unsigned EXEC_CYCLES = 1;
    localparam int          TIMEOUT     = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] op0 = '0, op1 = '0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       ack0, ack1, busy;
    logic [7:0] result;

    alu_arbiter #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .CLK(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [7:0] res;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat, l0, l1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit id, input logic [7:0] r, input string n);
        exp_t e;
        e.id = id; e.res = r; e.name = n;
        sb.push_back(e);
    endtask

    // One requester transaction: raise req, hold until own ack, drop req
    task automatic run_req(input bit id, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, output int cycles);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        if (id) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
        else    begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
        cycles = 0;
        while (!seen && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            seen = id ? ack1 : ack0;
        end
        if (!seen) check($sformatf("ack_timeout_req%0d", id), 32'(seen), 32'd1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Monitor: every ack is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (ack0 || ack1) begin
                check("single_ack", 32'(ack0 & ack1), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_id"}, 32'(ack1), 32'(mon_e.id));
                    check({mon_e.name, "_result"}, 32'(result), 32'(mon_e.res));
                end
            end else begin
                check("idle_result", 32'(result), 32'd0);
            end
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'b110, 4'h9, 4'h9, 8'h12},
        '{3'b101, 4'hC, 4'hA, 8'h79},
        '{3'b100, 4'h0, 4'h0, 8'h00},
        '{3'b100, 4'h0, 4'h2, 8'h0F},
        '{3'b011, 4'h4, 4'h6, 8'hF0},
        '{3'b011, 4'h4, 4'h7, 8'h00},
        '{3'b011, 4'h3, 4'h6, 8'h00},
        '{3'b010, 4'h3, 4'h0, 8'h3F},
        '{3'b001, 4'h0, 4'h0, 8'h3F},
        '{3'b000, 4'hF, 4'hF, 8'h00},
        '{3'b111, 4'h7, 4'h9, 8'h10},
        '{3'b111, 4'h3, 4'h4, 8'h07}
    };

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hold0", 32'(dut.hold0), 32'd0);
        check("rst_hold1", 32'(dut.hold1), 32'd0);
        reset = 1'b0;

        // Ripple add with carry out, plus request-to-ack latency
        push(1'b0, 8'h10, "radd_f_1");
        run_req(1'b0, 3'b111, 4'hF, 4'h1, lat);
        check("radd_latency", 32'(lat), 32'(EXEC_CYCLES + 2));
        check("radd_hold0", 32'(dut.hold0), 32'h10);

        // Opcode table on requester 0; hold0 follows every result
        for (int i = 0; i < 12; i++) begin
            push(1'b0, vecs[i].r, $sformatf("vec%0d", i));
            run_req(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_hold0", i), 32'(dut.hold0), 32'(vecs[i].r));
        end

        // Hold recall on requester 1
        push(1'b1, 8'h79, "logic_req1");
        run_req(1'b1, 3'b101, 4'hC, 4'hA, lat);
        push(1'b1, 8'h79, "recall_req1");
        run_req(1'b1, 3'b001, 4'h0, 4'h0, lat);
        check("recall_hold1", 32'(dut.hold1), 32'h79);

        // Contention with last grant on requester 1: requester 0 first either way
        push(1'b0, 8'h3F, "cont_a_req0");
        push(1'b1, 8'h50, "cont_a_req1");
        fork
            run_req(1'b0, 3'b010, 4'h3, 4'h0, l0);
            run_req(1'b1, 3'b010, 4'h5, 4'hF, l1);
        join
        check("cont_a_winner_lat", 32'(l0), 32'(EXEC_CYCLES + 2));
        check("cont_a_loser_lat", 32'(l1), 32'(2 * (EXEC_CYCLES + 2)));

        // Serve requester 0 alone, then contend: policy decides the order
        push(1'b0, 8'h1E, "solo_req0");
        run_req(1'b0, 3'b010, 4'h1, 4'h1, lat);
`ifdef ROUND_ROBIN_EN
        push(1'b1, 8'hF0, "cont_b_req1");
        push(1'b0, 8'h0F, "cont_b_req0");
`else
        push(1'b0, 8'h0F, "cont_b_req0");
        push(1'b1, 8'hF0, "cont_b_req1");
`endif
        fork
            run_req(1'b0, 3'b100, 4'h1, 4'h0, l0);
            run_req(1'b1, 3'b011, 4'h2, 4'h3, l1);
        join

        // Reset in the middle of EXEC aborts the operation
        @(negedge clk);
        op0 = 3'b110; a0 = 4'h9; b0 = 4'h9; req0 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_exec", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ack0", 32'(ack0), 32'd0);
        check("abort_hold0", 32'(dut.hold0), 32'd0);
        check("abort_hold1", 32'(dut.hold1), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_quiet_busy", 32'(busy), 32'd0);
        check("abort_quiet_hold0", 32'(dut.hold0), 32'd0);

        // Normal operation resumes
        push(1'b0, 8'h1E, "post_rst_radd");
        run_req(1'b0, 3'b111, 4'hF, 4'hF, lat);
        check("post_rst_latency", 32'(lat), 32'(EXEC_CYCLES + 2));

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
